// File: rtl/alsu_pkg.sv
// Types shared by the ALSU, its command issuer and its checker.
package alsu_pkg;

    localparam int ALSU_OUT_W = 6;

    typedef enum logic [2:0] {
        OR     = 3'd0,
        XOR    = 3'd1,
        ADD    = 3'd2,
        MUL    = 3'd3,
        SHIFT  = 3'd4,
        ROTATE = 3'd5
    } opcode_e;

    typedef struct packed {
        logic signed [2:0] a;
        logic signed [2:0] b;
        logic              cin;
        logic              serial_in;
        logic              red_op_a;
        logic              red_op_b;
        opcode_e           opcode;
        logic              bypass_a;
        logic              bypass_b;
        logic              direction;
    } alsu_cmd_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } issuer_state_e;

endpackage

// File: rtl/alsu_cmd_issuer_if.sv
// Command and result handshakes between the control fabric (master) and the issuer (slave).
interface alsu_cmd_issuer_if #(
    parameter int TAG_W = 4
);
    import alsu_pkg::*;

    logic                         cmd_valid;
    logic                         cmd_ready;
    alsu_cmd_t                    cmd;
    logic [TAG_W-1:0]             cmd_tag;
    logic                         res_valid;
    logic                         res_ready;
    logic signed [ALSU_OUT_W-1:0] res_out;
    logic [TAG_W-1:0]             res_tag;

    modport master (
        output cmd_valid, cmd, cmd_tag, res_ready,
        input  cmd_ready, res_valid, res_out, res_tag
    );

    modport slave (
        input  cmd_valid, cmd, cmd_tag, res_ready,
        output cmd_ready, res_valid, res_out, res_tag
    );

endinterface

// File: rtl/alsu_res_fifo.sv
// Fall-through result FIFO; a write and a pop may share an edge even when full.
module alsu_res_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_rd;
    logic          do_wr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign do_rd   = rd_en && (count_reg != '0);
    assign do_wr   = wr_en && ((count_reg != CW'(DEPTH)) || do_rd);
    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_rd) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/alsu_cmd_issuer.sv
// Issues tagged commands to the ALSU, follows them through its latency and
// returns captured results in order, with credit so no result is dropped.
module alsu_cmd_issuer
    import alsu_pkg::*;
#(
    parameter int LAT       = 2,
    parameter int RES_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    alsu_cmd_issuer_if.slave                 bus,
    output logic signed [2:0]                alsu_a,
    output logic signed [2:0]                alsu_b,
    output logic                             alsu_cin,
    output logic                             alsu_serial_in,
    output logic                             alsu_red_op_a,
    output logic                             alsu_red_op_b,
    output opcode_e                          alsu_opcode,
    output logic                             alsu_bypass_a,
    output logic                             alsu_bypass_b,
    output logic                             alsu_direction,
    input  logic signed [ALSU_OUT_W-1:0]     alsu_out,
    input  logic                             flush,
    output logic                             flush_done,
    output logic [$clog2(RES_DEPTH+1)-1:0]   outstanding
);
    localparam int OW = $clog2(RES_DEPTH+1);
    localparam int FW = TAG_W + ALSU_OUT_W;

    alsu_cmd_t        issue_reg;
    issuer_state_e    state_reg;
    logic             flush_done_reg;
    logic [OW-1:0]    outstanding_reg;
    logic             vld_pipe_reg [LAT+1];
    logic [TAG_W-1:0] tag_pipe_reg [LAT+1];
    logic             accept;
    logic             pop;
    logic [FW-1:0]    fifo_rd_data;
    logic [OW-1:0]    fifo_count;

    assign bus.cmd_ready = !rst && (state_reg == ST_RUN) && !flush
                           && (outstanding_reg < OW'(RES_DEPTH));
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign pop           = bus.res_valid && bus.res_ready;

    assign alsu_a         = issue_reg.a;
    assign alsu_b         = issue_reg.b;
    assign alsu_cin       = issue_reg.cin;
    assign alsu_serial_in = issue_reg.serial_in;
    assign alsu_red_op_a  = issue_reg.red_op_a;
    assign alsu_red_op_b  = issue_reg.red_op_b;
    assign alsu_opcode    = issue_reg.opcode;
    assign alsu_bypass_a  = issue_reg.bypass_a;
    assign alsu_bypass_b  = issue_reg.bypass_b;
    assign alsu_direction = issue_reg.direction;
    assign flush_done     = flush_done_reg;
    assign outstanding    = outstanding_reg;

    // Inputs hold between commands, so idle ALSU cycles recompute the last result harmlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_reg <= '0;
        end else if (accept) begin
            issue_reg <= bus.cmd;
        end
    end

    // Stage LAT is valid exactly when alsu_out reflects that command's inputs.
    genvar gi;
    generate
        for (gi = 0; gi <= LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_pipe_reg[0] <= 1'b0;
                        tag_pipe_reg[0] <= '0;
                    end else begin
                        vld_pipe_reg[0] <= accept;
                        tag_pipe_reg[0] <= bus.cmd_tag;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_pipe_reg[gi] <= 1'b0;
                        tag_pipe_reg[gi] <= '0;
                    end else begin
                        vld_pipe_reg[gi] <= vld_pipe_reg[gi-1];
                        tag_pipe_reg[gi] <= tag_pipe_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_reg <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding_reg <= outstanding_reg + OW'(1);
                2'b01:   outstanding_reg <= outstanding_reg - OW'(1);
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            flush_done_reg <= 1'b0;
        end else begin
            flush_done_reg <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (flush) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding_reg == '0) begin
                        state_reg      <= ST_DONE;
                        flush_done_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_RUN;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    alsu_res_fifo #(
        .DEPTH (RES_DEPTH),
        .W     (FW)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld_pipe_reg[LAT]),
        .wr_data ({tag_pipe_reg[LAT], alsu_out}),
        .rd_en   (bus.res_ready),
        .rd_data (fifo_rd_data),
        .count   (fifo_count)
    );

    assign bus.res_valid = (fifo_count != '0);
    assign bus.res_out   = fifo_rd_data[ALSU_OUT_W-1:0];
    assign bus.res_tag   = fifo_rd_data[FW-1:ALSU_OUT_W];

endmodule
